// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges ALU and buffered long-latency results onto the single register-file write port
module rf_writeback_arbiter #(
  parameter int DW = 32,
  parameter int NREG = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [DW-1:0] alu_wd,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [4:0]    lu_rd,
  input  logic [DW-1:0] lu_wd,
  input  logic          iss_valid,
  input  logic [4:0]    iss_rd,
  input  logic [4:0]    chk_rs1,
  input  logic [4:0]    chk_rs2,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          we,
  output logic [4:0]    rd,
  output logic [DW-1:0] wd
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DW+4:0]   mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [CW-1:0]   cnt;
  logic [NREG-1:0] pending, set_mask, clr_mask;
  logic            push, pop, empty, sel, sel_we;
  logic [4:0]      sel_rd;
  logic [DW-1:0]   sel_wd;
  assign empty    = cnt == '0;
  assign lu_ready = cnt != CW'(DEPTH);
  assign push     = lu_valid && lu_ready;
  assign pop      = !alu_valid && !empty;
  assign sel      = alu_valid || !empty;
  assign sel_rd   = alu_valid ? alu_rd : mem[rp][DW+4:DW];
  assign sel_wd   = alu_valid ? alu_wd : mem[rp][DW-1:0];
  assign sel_we   = sel && sel_rd != '0;
  assign set_mask = (iss_valid && iss_rd != '0) ? (NREG'(1) << iss_rd) : '0;
  assign clr_mask = sel_we ? (NREG'(1) << sel_rd) : '0;
  assign rs1_busy = pending[chk_rs1] && chk_rs1 != '0;
  assign rs2_busy = pending[chk_rs2] && chk_rs2 != '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {lu_rd, lu_wd};
  // set is OR-ed after clear so a younger issue to the committing register stays pending
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      pending <= '0;
      we      <= 1'b0;
      rd      <= '0;
      wd      <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt     <= cnt + CW'(push) - CW'(pop);
      pending <= ((pending & ~clr_mask) | set_mask) & ~NREG'(1);
      we      <= sel_we;
      if (sel) begin
        rd <= sel_rd;
        wd <= sel_wd;
      end
    end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed vectors with a write-port scoreboard
module tb_rf_writeback_arbiter;
  logic        clk, reset;
  logic        alu_valid, lu_valid, lu_ready, iss_valid;
  logic [4:0]  alu_rd, lu_rd, iss_rd, chk_rs1, chk_rs2, rd;
  logic [31:0] alu_wd, lu_wd, wd;
  logic        rs1_busy, rs2_busy, we;
  int          checks, errors;
  logic [36:0] exp_q[$];

  rf_writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_wd(lu_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we(we), .rd(rd), .wd(wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  // every committed write must match the oldest outstanding expectation
  always @(negedge clk)
    if (!reset && we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual rd=%0d wd=%0h expected none", rd, wd);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rd, wd} !== e) begin
          errors++;
          $display("FAIL write actual rd=%0d wd=%0h expected rd=%0d wd=%0h", rd, wd, e[36:32], e[31:0]);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic acc;
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_wd = '0;
    iss_valid = 1'b0; iss_rd = '0; chk_rs1 = 5'd5; chk_rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_wd", 64'(wd), 64'd0);
    chk("rst_lu_ready", 64'(lu_ready), 64'd1);
    chk("rst_busy", 64'(rs1_busy), 64'd0);
    reset = 1'b0;
    tick();
    // 1) ALU single-cycle latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hA5A5A5A5;
    expect_wr(5'd5, 32'hA5A5A5A5);
    tick();
    alu_valid = 1'b0;
    chk("t1_we", 64'(we), 64'd1);
    chk("t1_rd", 64'(rd), 64'd5);
    tick();
    chk("t1_we_off", 64'(we), 64'd0);
    // 2) long-latency result appears two edges after acceptance
    lu_valid = 1'b1; lu_rd = 5'd7; lu_wd = 32'h11;
    chk("t2_ready", 64'(lu_ready), 64'd1);
    expect_wr(5'd7, 32'h11);
    tick();
    lu_valid = 1'b0;
    chk("t2_no_bypass", 64'(we), 64'd0);
    chk("t2_ready_hold", 64'(lu_ready), 64'd1);
    tick();
    chk("t2_we", 64'(we), 64'd1);
    chk("t2_rd", 64'(rd), 64'd7);
    tick();
    // 3) ALU priority, FIFO fills, in-order drain, simultaneous push/pop
    expect_wr(5'd10, 32'h100); expect_wr(5'd11, 32'h101);
    expect_wr(5'd12, 32'h102); expect_wr(5'd13, 32'h103);
    expect_wr(5'd1, 32'h201); expect_wr(5'd2, 32'h202); expect_wr(5'd3, 32'h203);
    alu_valid = 1'b1; alu_rd = 5'd10; alu_wd = 32'h100;
    lu_valid = 1'b1; lu_rd = 5'd1; lu_wd = 32'h201;
    tick();
    alu_rd = 5'd11; alu_wd = 32'h101; lu_rd = 5'd2; lu_wd = 32'h202;
    tick();
    chk("t3_full", 64'(lu_ready), 64'd0);
    alu_rd = 5'd12; alu_wd = 32'h102; lu_rd = 5'd3; lu_wd = 32'h203;
    tick();
    alu_rd = 5'd13; alu_wd = 32'h103;
    tick();
    alu_valid = 1'b0;
    chk("t3_still_full", 64'(lu_ready), 64'd0);
    tick();
    chk("t3_slot_free", 64'(lu_ready), 64'd1);
    tick();
    lu_valid = 1'b0;
    tick();
    tick();
    chk("t3_drained", 64'(lu_ready), 64'd1);
    // 4) full FIFO then streaming with pointer wrap over 10 results
    expect_wr(5'd21, 32'h2100); expect_wr(5'd22, 32'h2200);
    for (int i = 0; i < 10; i++) expect_wr(5'(11 + i), 32'h3000 + i);
    alu_valid = 1'b1; alu_rd = 5'd21; alu_wd = 32'h2100;
    lu_valid = 1'b1; lu_rd = 5'd11; lu_wd = 32'h3000;
    tick();
    alu_rd = 5'd22; alu_wd = 32'h2200; lu_rd = 5'd12; lu_wd = 32'h3001;
    tick();
    alu_valid = 1'b0;
    chk("t4_full", 64'(lu_ready), 64'd0);
    k = 2;
    for (int c = 0; c < 40 && k < 10; c++) begin
      lu_valid = 1'b1; lu_rd = 5'(11 + k); lu_wd = 32'h3000 + k;
      acc = lu_ready;
      tick();
      if (acc) k++;
    end
    lu_valid = 1'b0;
    chk("t4_accepts", 64'(k), 64'd10);
    repeat (4) tick();
    chk("t4_empty", 64'(lu_ready), 64'd1);
    // 5) pending scoreboard
    chk_rs1 = 5'd9;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    chk("t5_busy_set", 64'(rs1_busy), 64'd1);
    repeat (3) tick();
    chk("t5_busy_hold", 64'(rs1_busy), 64'd1);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = 32'h99;
    expect_wr(5'd9, 32'h99);
    tick();
    alu_valid = 1'b0;
    chk("t5_commit_we", 64'(we), 64'd1);
    chk("t5_busy_clr", 64'(rs1_busy), 64'd0);
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = 32'h98;
    expect_wr(5'd9, 32'h98);
    tick();
    iss_valid = 1'b0;
    alu_wd = 32'h97;
    expect_wr(5'd9, 32'h97);
    chk("t5_set_wins", 64'(rs1_busy), 64'd1);
    tick();
    alu_valid = 1'b0;
    chk("t5_busy_clr2", 64'(rs1_busy), 64'd0);
    iss_valid = 1'b1; iss_rd = 5'd0; chk_rs1 = 5'd0;
    tick();
    iss_valid = 1'b0;
    chk("t5_x0_busy", 64'(rs1_busy), 64'd0);
    chk_rs2 = 5'd12;
    iss_valid = 1'b1; iss_rd = 5'd12;
    tick();
    iss_valid = 1'b0;
    chk("t5_rs2_busy", 64'(rs2_busy), 64'd1);
    lu_valid = 1'b1; lu_rd = 5'd12; lu_wd = 32'h12;
    expect_wr(5'd12, 32'h12);
    tick();
    lu_valid = 1'b0;
    chk("t5_rs2_buffered", 64'(rs2_busy), 64'd1);
    tick();
    chk("t5_rs2_clr", 64'(rs2_busy), 64'd0);
    tick();
    // 6) x0 write suppressed; reset flushes buffered results
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'hFF;
    tick();
    alu_valid = 1'b0;
    chk("t6_x0_we", 64'(we), 64'd0);
    expect_wr(5'd23, 32'h2300); expect_wr(5'd25, 32'h2500);
    alu_valid = 1'b1; alu_rd = 5'd23; alu_wd = 32'h2300;
    lu_valid = 1'b1; lu_rd = 5'd24; lu_wd = 32'h2400;
    tick();
    alu_rd = 5'd25; alu_wd = 32'h2500; lu_rd = 5'd26; lu_wd = 32'h2600;
    tick();
    alu_valid = 1'b0; lu_valid = 1'b0;
    chk("t6_full", 64'(lu_ready), 64'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_rst_we", 64'(we), 64'd0);
    chk("t6_rst_ready", 64'(lu_ready), 64'd1);
    chk("t6_rst_rd", 64'(rd), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("t6_no_writes", 64'(we), 64'd0);
    chk("t6_ready", 64'(lu_ready), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
